// File: rtl/memoryaccess_stage_if.sv
// Data-memory bus between the RV32I memory-access stage and the data memory.
// The request side is held stable until ack; rdata is valid in the ack cycle.
interface memoryaccess_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ack, rdata
  );
endinterface

// File: rtl/memoryaccess_stage.sv
// RV32I pipeline stage 4: stage register, load/store over a req/ack data bus, writeback register.
// Optional macro DMEM_TIMEOUT_EN adds a REQ_TIMEOUT-cycle bus timeout that retires with o_bus_err.
module memoryaccess_stage #(
  parameter int unsigned REQ_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ce,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_wr_rd,
  output logic        o_stall,
  output logic        o_ce,
  output logic [4:0]  o_rd_addr,
  output logic        o_wr_rd,
  output logic        o_rd_valid,
  output logic [31:0] o_rd,
  memoryaccess_stage_if.master dmem,
  output logic        o_wb_ce,
  output logic [4:0]  o_wb_rd_addr,
  output logic        o_wb_wr_rd,
  output logic [31:0] o_wb_rd,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(REQ_TIMEOUT);

  logic        is_load_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] store_data_q;

  logic        mem_op;
  logic        misaligned;
  logic        mis_err;
  logic        req;
  logic        timeout;
  logic        stall;
  logic [0:0]  state;
  logic [0:0]  state_next;
  logic [31:0] load_data;
  logic [31:0] wdata_lanes;
  logic [3:0]  wstrb_lanes;

  assign mem_op = is_load_q | is_store_q;

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    misaligned = 1'b0;
    case (funct3_q[1:0])
      2'b01:        misaligned = o_rd[0];
      2'b10, 2'b11: misaligned = |o_rd[1:0];
      default:      misaligned = 1'b0;
    endcase
  end

  assign mis_err = o_ce & mem_op & misaligned;
  assign req     = o_ce & mem_op & ~misaligned;
  assign stall   = req & ~dmem.ack & ~timeout;

`ifdef DMEM_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // Counts stalled request cycles; any retire (stall low) restarts it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   wait_cnt <= '0;
    else if (stall) wait_cnt <= wait_cnt + 16'd1;
    else            wait_cnt <= '0;
  end

  assign timeout = req & ~dmem.ack & (wait_cnt == TIMEOUT_LIMIT);
`else
  logic timeout_unused;
  assign timeout_unused = ^TIMEOUT_LIMIT;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req & ~dmem.ack & ~timeout)  state_next = ST_WAIT;
      ST_WAIT: if (~req | dmem.ack | timeout)   state_next = ST_IDLE;
      default:                                  state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Load lane selection and extension; unlisted funct3 codes pass the raw word.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'h00;
    case (o_rd[1:0])
      2'b00: b = dmem.rdata[7:0];
      2'b01: b = dmem.rdata[15:8];
      2'b10: b = dmem.rdata[23:16];
      2'b11: b = dmem.rdata[31:24];
      default: b = 8'h00;
    endcase
    h = o_rd[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{b[7]}}, b};
      3'b001:  load_data = {{16{h[15]}}, h};
      3'b100:  load_data = {24'h0, b};
      3'b101:  load_data = {16'h0, h};
      default: load_data = dmem.rdata;
    endcase
  end

  always_comb begin
    wdata_lanes = store_data_q;
    wstrb_lanes = 4'b1111;
    case (funct3_q[1:0])
      2'b00: begin
        wdata_lanes = {4{store_data_q[7:0]}};
        wstrb_lanes = 4'b0001 << o_rd[1:0];
      end
      2'b01: begin
        wdata_lanes = {2{store_data_q[15:0]}};
        wstrb_lanes = o_rd[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_lanes = store_data_q;
        wstrb_lanes = 4'b1111;
      end
    endcase
  end

  assign dmem.req   = req;
  assign dmem.we    = req & is_store_q;
  assign dmem.addr  = {o_rd[31:2], 2'b00};
  assign dmem.wdata = wdata_lanes;
  assign dmem.wstrb = (req & is_store_q) ? wstrb_lanes : 4'b0000;

  assign o_stall      = stall;
  assign o_rd_valid   = o_ce & ~is_load_q;
  assign o_misaligned = mis_err;
  assign o_bus_err    = timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ce         <= 1'b0;
      o_rd_addr    <= '0;
      o_wr_rd      <= 1'b0;
      o_rd         <= '0;
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      store_data_q <= '0;
    end else if (!stall) begin
      o_ce         <= i_ce;
      o_rd_addr    <= i_rd_addr;
      o_wr_rd      <= i_wr_rd;
      o_rd         <= i_alu_result;
      is_load_q    <= i_is_load;
      is_store_q   <= i_is_store;
      funct3_q     <= i_funct3;
      store_data_q <= i_store_data;
    end
  end

  // Stores, misaligned accesses and timeouts retire without writing rd.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_ce      <= 1'b0;
      o_wb_rd_addr <= '0;
      o_wb_wr_rd   <= 1'b0;
      o_wb_rd      <= '0;
    end else if (!stall) begin
      o_wb_ce      <= o_ce;
      o_wb_rd_addr <= o_rd_addr;
      o_wb_wr_rd   <= o_ce & o_wr_rd & ~is_store_q & ~mis_err & ~timeout;
      o_wb_rd      <= is_load_q ? load_data : o_rd;
    end
  end

endmodule

// File: tb/tb_memoryaccess_stage.sv
// Directed bench for memoryaccess_stage: table of single-instruction vectors plus
// hand-written sequences for reset mid-access, back-to-back zero-wait ops and timeout.
module tb_memoryaccess_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_ce = 1'b0;
  logic        i_is_load = 1'b0;
  logic        i_is_store = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_alu_result = '0;
  logic [31:0] i_store_data = '0;
  logic [4:0]  i_rd_addr = '0;
  logic        i_wr_rd = 1'b0;
  logic        o_stall, o_ce, o_wr_rd, o_rd_valid;
  logic [4:0]  o_rd_addr, o_wb_rd_addr;
  logic [31:0] o_rd, o_wb_rd;
  logic        o_wb_ce, o_wb_wr_rd, o_misaligned, o_bus_err;

  memoryaccess_stage_if dmem ();

  memoryaccess_stage #(.REQ_TIMEOUT(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ce         (i_ce),
    .i_is_load    (i_is_load),
    .i_is_store   (i_is_store),
    .i_funct3     (i_funct3),
    .i_alu_result (i_alu_result),
    .i_store_data (i_store_data),
    .i_rd_addr    (i_rd_addr),
    .i_wr_rd      (i_wr_rd),
    .o_stall      (o_stall),
    .o_ce         (o_ce),
    .o_rd_addr    (o_rd_addr),
    .o_wr_rd      (o_wr_rd),
    .o_rd_valid   (o_rd_valid),
    .o_rd         (o_rd),
    .dmem         (dmem),
    .o_wb_ce      (o_wb_ce),
    .o_wb_rd_addr (o_wb_rd_addr),
    .o_wb_wr_rd   (o_wb_wr_rd),
    .o_wb_rd      (o_wb_rd),
    .o_misaligned (o_misaligned),
    .o_bus_err    (o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic        is_load;
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] rdata;
    int          waits;
    logic        exp_req;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_wr;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [151:0] all_outs();
    return {o_stall, o_ce, o_rd_addr, o_wr_rd, o_rd_valid, o_rd,
            dmem.req, dmem.we, dmem.addr, dmem.wdata, dmem.wstrb,
            o_wb_ce, o_wb_rd_addr, o_wb_wr_rd, o_wb_rd, o_misaligned, o_bus_err};
  endfunction

  function automatic vec_t mk(string name, logic ld, logic st, logic [2:0] f3,
                              logic [31:0] alu, logic [31:0] sdata, logic [4:0] rd, logic wr,
                              logic [31:0] rdata, int waits, logic exp_req, logic exp_mis,
                              logic [31:0] exp_addr, logic [31:0] exp_wdata, logic [3:0] exp_wstrb,
                              logic exp_wr, logic chk_rd, logic [31:0] exp_rd);
    vec_t v;
    v.name = name; v.is_load = ld; v.is_store = st; v.f3 = f3; v.alu = alu; v.sdata = sdata;
    v.rd = rd; v.wr = wr; v.rdata = rdata; v.waits = waits; v.exp_req = exp_req;
    v.exp_mis = exp_mis; v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
    v.exp_wstrb = exp_wstrb; v.exp_wr = exp_wr; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic drive(input logic ce, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] sdata,
                       input logic [4:0] rd, input logic wr);
    i_ce = ce; i_is_load = ld; i_is_store = st; i_funct3 = f3;
    i_alu_result = alu; i_store_data = sdata; i_rd_addr = rd; i_wr_rd = wr;
  endtask

  task automatic run_vec(input vec_t v);
    int  cyc;
    int  stalls;
    bit  done;
    @(posedge i_clk); #1;
    drive(1'b1, v.is_load, v.is_store, v.f3, v.alu, v.sdata, v.rd, v.wr);
    dmem.ack = 1'b0;
    dmem.rdata = v.rdata;
    @(posedge i_clk); #1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    cyc = 0; stalls = 0; done = 0;
    while (!done && cyc < 40) begin
      dmem.ack = (cyc >= v.waits);
      @(negedge i_clk);
      if (cyc == 0) begin
        check({v.name, ".ce"},       o_ce, 1'b1);
        check({v.name, ".req"},      dmem.req, v.exp_req);
        check({v.name, ".mis"},      o_misaligned, v.exp_mis);
        check({v.name, ".rd_valid"}, o_rd_valid, !v.is_load);
      end
      if (v.exp_req) begin
        check({v.name, ".addr"}, dmem.addr, v.exp_addr);
        check({v.name, ".we"},   dmem.we, v.is_store);
        if (v.is_store) begin
          check({v.name, ".wdata"}, dmem.wdata, v.exp_wdata);
          check({v.name, ".wstrb"}, dmem.wstrb, v.exp_wstrb);
        end
      end
      if (o_stall) stalls++;
      else         done = 1;
      @(posedge i_clk); #1;
      cyc++;
    end
    dmem.ack = 1'b0;
    check({v.name, ".retire_bound"}, done, 1'b1);
    check({v.name, ".stalls"}, stalls, v.exp_req ? v.waits : 0);
    check({v.name, ".wb_ce"}, o_wb_ce, 1'b1);
    check({v.name, ".wb_rd_addr"}, o_wb_rd_addr, v.rd);
    check({v.name, ".wb_wr_rd"}, o_wb_wr_rd, v.exp_wr);
    if (v.chk_rd) check({v.name, ".wb_rd"}, o_wb_rd, v.exp_rd);
    check({v.name, ".mis_after"}, o_misaligned, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    bit err_seen;
    dmem.ack = 1'b0;
    dmem.rdata = '0;

    //          name     ld st f3      alu           sdata         rd  wr rdata         w  req mis addr          wdata         wstrb    wr chk exp_rd
    vecs.push_back(mk("add",   0, 0, 3'b000, 32'h00001234, 32'h0,        5, 1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        4'b0000, 1, 1, 32'h00001234));
    vecs.push_back(mk("lb",    1, 0, 3'b000, 32'h00000103, 32'h0,        6, 1, 32'h80000000, 2, 1, 0, 32'h00000100, 32'h0,        4'b0000, 1, 1, 32'hFFFFFF80));
    vecs.push_back(mk("lbu",   1, 0, 3'b100, 32'h00000103, 32'h0,        6, 1, 32'h80000000, 2, 1, 0, 32'h00000100, 32'h0,        4'b0000, 1, 1, 32'h00000080));
    vecs.push_back(mk("lh",    1, 0, 3'b001, 32'h00000102, 32'h0,        8, 1, 32'h80011234, 0, 1, 0, 32'h00000100, 32'h0,        4'b0000, 1, 1, 32'hFFFF8001));
    vecs.push_back(mk("lhu",   1, 0, 3'b101, 32'h00000100, 32'h0,        9, 1, 32'h1234F00D, 1, 1, 0, 32'h00000100, 32'h0,        4'b0000, 1, 1, 32'h0000F00D));
    vecs.push_back(mk("lw",    1, 0, 3'b010, 32'h00000104, 32'h0,       10, 1, 32'hDEADBEEF, 0, 1, 0, 32'h00000104, 32'h0,        4'b0000, 1, 1, 32'hDEADBEEF));
    vecs.push_back(mk("lb_hi", 1, 0, 3'b000, 32'h000007FF, 32'h0,       11, 1, 32'h7F000000, 3, 1, 0, 32'h000007FC, 32'h0,        4'b0000, 1, 1, 32'h0000007F));
    vecs.push_back(mk("sh",    0, 1, 3'b001, 32'h00000202, 32'h0000ABCD, 1, 1, 32'h0,        1, 1, 0, 32'h00000200, 32'hABCDABCD, 4'b1100, 0, 1, 32'h00000202));
    vecs.push_back(mk("sb",    0, 1, 3'b000, 32'h00000201, 32'h00000012, 0, 0, 32'h0,        0, 1, 0, 32'h00000200, 32'h12121212, 4'b0010, 0, 1, 32'h00000201));
    vecs.push_back(mk("sw",    0, 1, 3'b010, 32'h00000300, 32'hCAFEF00D, 0, 0, 32'h0,        2, 1, 0, 32'h00000300, 32'hCAFEF00D, 4'b1111, 0, 1, 32'h00000300));
    vecs.push_back(mk("lw_mis",1, 0, 3'b010, 32'h00000102, 32'h0,       12, 1, 32'h0,        0, 0, 1, 32'h0,        32'h0,        4'b0000, 0, 0, 32'h0));
    vecs.push_back(mk("lh_mis",1, 0, 3'b001, 32'h00000101, 32'h0,       13, 1, 32'h0,        0, 0, 1, 32'h0,        32'h0,        4'b0000, 0, 0, 32'h0));
    vecs.push_back(mk("add_nw",0, 0, 3'b010, 32'h00000003, 32'h0,       14, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        4'b0000, 0, 1, 32'h00000003));

    repeat (2) @(posedge i_clk);
    #1;
    check("reset_outs", all_outs(), '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("post_reset_outs", all_outs(), '0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back LW then SW with ack tied high.
    dmem.ack = 1'b1;
    dmem.rdata = 32'h11223344;
    @(posedge i_clk); #1;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h00000400, 32'h0, 5'd7, 1'b1);
    @(posedge i_clk); #1;
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h00000404, 32'h00000055, 5'd0, 1'b0);
    @(negedge i_clk);
    check("b2b.lw_req",      {dmem.req, dmem.we}, 2'b10);
    check("b2b.lw_rd_valid", o_rd_valid, 1'b0);
    check("b2b.lw_stall",    o_stall, 1'b0);
    @(posedge i_clk); #1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge i_clk);
    check("b2b.sw_req",      {dmem.req, dmem.we}, 2'b11);
    check("b2b.sw_addr",     dmem.addr, 32'h00000404);
    check("b2b.sw_rd_valid", o_rd_valid, 1'b1);
    check("b2b.sw_stall",    o_stall, 1'b0);
    check("b2b.lw_wb",       {o_wb_ce, o_wb_rd_addr, o_wb_wr_rd, o_wb_rd}, {1'b1, 5'd7, 1'b1, 32'h11223344});
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("b2b.sw_wb",       {o_wb_ce, o_wb_wr_rd, dmem.req}, 3'b100);
    dmem.ack = 1'b0;

    // Reset asserted while a load waits for ack.
    @(posedge i_clk); #1;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h00000600, 32'h0, 5'd3, 1'b1);
    @(posedge i_clk); #1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge i_clk);
    check("rst_mid.req_before", {dmem.req, o_stall}, 2'b11);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_mid.outs", all_outs(), '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_mid.no_retire", {o_wb_ce, o_wb_wr_rd, dmem.req}, 3'b000);

    // Ack never arrives.
    @(posedge i_clk); #1;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h00000500, 32'h0, 5'd9, 1'b1);
    @(posedge i_clk); #1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    stalls = 0;
    err_seen = 0;
`ifdef DMEM_TIMEOUT_EN
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (!o_stall) break;
      stalls++;
      if (o_bus_err) err_seen = 1;
      @(posedge i_clk); #1;
    end
    check("tmo.stalls",   stalls, 4);
    check("tmo.early_err", err_seen, 1'b0);
    check("tmo.err_pulse", {o_bus_err, dmem.req}, 2'b11);
    @(posedge i_clk); #1;
    check("tmo.wb", {o_wb_ce, o_wb_rd_addr, o_wb_wr_rd, o_bus_err}, {1'b1, 5'd9, 1'b0, 1'b0});
    run_vec(vecs[0]);
`else
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      if (o_stall) stalls++;
      if (o_bus_err) err_seen = 1;
    end
    check("noto.stalls",  stalls, 10);
    check("noto.bus_err", err_seen, 1'b0);
    check("noto.no_retire", o_wb_ce, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("noto.reset_outs", all_outs(), '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_vec(vecs[0]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/memoryaccess_stage.md
# memoryaccess_stage

Stage 4 of the RV32I five-stage pipeline: it registers the execute-stage result and runs loads and stores against the data-memory bus with a req/ack handshake. It presents its stage register to operand forwarding as the stage-4 rd source, and delivers the retired rd value to writeback. It back-pressures the pipeline while a memory access is outstanding.

## Interface
- `REQ_TIMEOUT`, default 255: maximum cycles to wait for `i_dmem_ack` (only used with `DMEM_TIMEOUT_EN`); 1..65535.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_ce`  in  1  execute stage holds a valid instruction for this stage.
- `i_is_load` / `i_is_store`  in  1  instruction class (mutually exclusive).
- `i_funct3`  in  3  width/sign select (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB/SH/SW=000/001/010).
- `i_alu_result`  in  32  effective address (load/store) or rd value (others).
- `i_store_data`  in  32  rs2 after WB→MEM forwarding.
- `i_rd_addr`  in  5  destination register.
- `i_wr_rd`  in  1  instruction writes rd.
- `o_stall`  out  1  hold execute and earlier stages.
- `o_ce`  out  1  stage register valid (forwarding "stage 4 enabled").
- `o_rd_addr`  out  5  stage-register rd address.
- `o_wr_rd`  out  1  stage-register write-enable.
- `o_rd_valid`  out  1  rd value already final (0 for loads).
- `o_rd`  out  32  stage-register `i_alu_result`.
- `o_dmem_req`  out  1  bus request.
- `o_dmem_we`  out  1  write request.
- `o_dmem_addr`  out  32  word-aligned address (`o_rd[31:2]`, `2'b00`).
- `o_dmem_wdata`  out  32  store data lane-replicated.
- `o_dmem_wstrb`  out  4  byte enables.
- `i_dmem_ack`  in  1  request complete; may arrive in the same cycle as the request.
- `i_dmem_rdata`  in  32  read word, valid with ack.
- `o_wb_ce`  out  1  writeback stage valid.
- `o_wb_rd_addr`  out  5  writeback rd address.
- `o_wb_wr_rd`  out  1  writeback rd write-enable.
- `o_wb_rd`  out  32  final rd value.
- `o_misaligned`  out  1  one-cycle pulse on a misaligned load/store.
- `o_bus_err`  out  1  one-cycle pulse on a timeout (only with `DMEM_TIMEOUT_EN`, else tied 0).

## Operation
- **Stage register** (`o_ce`, `o_rd*`, `o_wr_rd`, class, funct3, store data): loads from the inputs at every edge where `o_stall`=0. `o_ce` takes `i_ce`.
- **Frozen register:** while `o_stall`=1 the stage register holds.
- **`o_rd_valid`:** `o_ce & ~is_load`.
- **FSM states:** IDLE and WAIT.
  - Only IDLE exists when no memory instruction is in stage.
  - A valid, aligned load/store in the stage register puts the FSM in WAIT, asserting `o_dmem_req` combinationally.
  - WAIT → IDLE on ack (or timeout).
- **`o_stall`:** `o_ce & mem_op & aligned & ~i_dmem_ack & ~timeout`.
- **Loads:**
  - Select the byte/half at `o_rd[1:0]`.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
- **Stores:**
  - SB: wdata={4{b}}, wstrb=`0001<<addr[1:0]`.
  - SH: wdata={2{h}}, wstrb=`0011<<addr[1]*2`.
  - SW: wstrb=`1111`.
  - `o_dmem_we`=1.
- **Misalignment:** halfword with addr[0]=1, or word with addr[1:0]≠0.
  - No request is issued and no stall.
  - `o_misaligned` pulses in the retire cycle.
  - Retires with `o_wb_wr_rd`=0.
- **Writeback register:** loads on every edge where `o_stall`=0.
  - `o_wb_ce`=`o_ce`.
  - `o_wb_rd` = formatted load data or `o_rd`.
  - `o_wb_wr_rd` = `o_wr_rd` & no error.
  - Bubbles (`o_ce`=0) propagate as `o_wb_ce`=0.
- **Stores:** always retire with `o_wb_wr_rd`=0.

## Timing
- **Reset:** all outputs 0, FSM IDLE, timeout counter 0. Asserting `i_rst_n` low mid-access drops `o_dmem_req` immediately; nothing retires.
- **Non-memory ops:** in stage register edge N → `o_wb_*` valid after edge N+1. Throughput 1/cycle.
- **Zero-wait memory** (ack in the request cycle): no stall, same latency as non-memory ops.
- **k wait cycles:** `o_stall` high k cycles. `o_dmem_req`, addr, we, wdata and wstrb are stable throughout. Retire at the edge where ack=1.
- **`i_dmem_ack` outside a request:** ignored.
- **Back-to-back memory ops:** the next request is asserted in the cycle immediately after the ack edge, with no idle cycle.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - A 16-bit counter counts cycles with req=1 and ack=0.
  - When the count reaches `REQ_TIMEOUT`, in that cycle: `o_stall`=0, `o_bus_err` pulses, and the instruction retires with `o_wb_wr_rd`=0.
  - The counter clears on every retire.
- Not defined: no counter; the block waits for ack indefinitely and `o_bus_err`=0.

## Test plan
- **Reset mid-access:** reset released, then ADD result 0x1234 rd=5 → `o_wb_ce`=1, `o_wb_rd_addr`=5, `o_wb_rd`=0x1234 one edge later, `o_stall` never high. Reassert reset mid-access → all outputs 0 immediately.
- **Load with wait states:** LB addr 0x103, rdata 0x80_00_00_00, ack after 2 wait cycles → `o_stall` high 2 cycles, `o_dmem_addr`=0x100, `o_wb_rd`=0xFFFFFF80. LBU under the same conditions → 0x00000080.
- **Store lanes:** SH addr 0x202, data 0xABCD → `o_dmem_wdata`=0xABCDABCD, `o_dmem_wstrb`=1100, `o_dmem_we`=1, `o_wb_wr_rd`=0. SB addr 0x201 → `o_dmem_wstrb`=0010.
- **Misaligned word load:** LW addr 0x102 → `o_dmem_req` stays 0, `o_misaligned` pulses once, `o_wb_wr_rd`=0, no stall.
- **Back-to-back zero-wait memory:** LW then SW, with ack tied high → two consecutive request cycles, `o_stall` always 0, `o_rd_valid`=0 during the LW and 1 during the SW.
- **Timeout:** with `DMEM_TIMEOUT_EN` and `REQ_TIMEOUT`=4, ack never asserted → 4 stall cycles, `o_bus_err` pulses, `o_wb_wr_rd`=0, next instruction proceeds.
